// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Control-flow functional unit of the execute stage. Computes the link
//   address, the actual branch/jump target and the taken decision, checks them
//   against the frontend prediction and reports a resolved-branch record, a
//   mispredict flag and an instruction-address-misaligned exception. Every
//   output is registered, so results appear one cycle after issue. A new
//   instruction may issue every cycle.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   debug_mode_i                 suppresses the misaligned exception
//   fu_valid_i, branch_valid_i   issue qualifiers (both high = active)
//   is_jalr_i                    register-indirect jump vs. branch/JAL
//   operand_a_i, imm_i, pc_i     rs1, sign-extended offset, instruction pc
//   is_compressed_instr_i        16-bit instruction (link = pc + 2)
//   branch_comp_res_i            ALU compare result
//   bp_cf_i, bp_predict_address_i  frontend prediction (type, target)
//   branch_result_o              link address
//   resolve_branch_o, res_*_o    resolved-branch record
//   ex_valid_o, ex_cause_o, ex_tval_o  misaligned-target exception
module branch_resolve_unit #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned XLEN = 64,
  parameter bit          RVC  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            debug_mode_i,
  input  logic            fu_valid_i,
  input  logic            branch_valid_i,
  input  logic            is_jalr_i,
  input  logic [VLEN-1:0] operand_a_i,
  input  logic [VLEN-1:0] imm_i,
  input  logic [VLEN-1:0] pc_i,
  input  logic            is_compressed_instr_i,
  input  logic            branch_comp_res_i,
  input  logic [2:0]      bp_cf_i,
  input  logic [VLEN-1:0] bp_predict_address_i,
  output logic [VLEN-1:0] branch_result_o,
  output logic            resolve_branch_o,
  output logic            res_valid_o,
  output logic [VLEN-1:0] res_pc_o,
  output logic [VLEN-1:0] res_target_o,
  output logic            res_is_taken_o,
  output logic            res_is_mispredict_o,
  output logic [2:0]      res_cf_type_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_cause_o,
  output logic [XLEN-1:0] ex_tval_o
);

  typedef enum logic [2:0] {
    CF_NOCF   = 3'd0,
    CF_BRANCH = 3'd1,
    CF_JUMP   = 3'd2,
    CF_JUMPR  = 3'd3,
    CF_RETURN = 3'd4
  } cf_e;

  logic            act;
  logic [VLEN-1:0] next_pc;
  logic [VLEN-1:0] tgt;
  logic            taken;
  logic            mispredict;
  logic            misaligned;

  logic [VLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic [VLEN-1:0] pc_q, pc_d;
  logic [VLEN-1:0] target_q, target_d;
  logic            taken_q, taken_d;
  logic            mispredict_q, mispredict_d;
  logic [2:0]      cf_type_q, cf_type_d;
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_cause_q, ex_cause_d;
  logic [XLEN-1:0] ex_tval_q, ex_tval_d;

  assign act = fu_valid_i & branch_valid_i;

  // Target, taken and mispredict decision for the instruction being issued.
  always_comb begin
    next_pc    = pc_i + (is_compressed_instr_i ? VLEN'(2) : VLEN'(4));
    tgt        = '0;
    taken      = 1'b0;
    mispredict = 1'b0;
    if (is_jalr_i) begin
      tgt        = (operand_a_i + imm_i) & ~VLEN'(1);
      taken      = 1'b1;
      mispredict = !((bp_cf_i == CF_JUMPR) || (bp_cf_i == CF_RETURN))
                 || (bp_predict_address_i != tgt);
    end else begin
      tgt        = pc_i + imm_i;
      taken      = branch_comp_res_i;
      mispredict = (taken != (bp_cf_i == CF_BRANCH))
                 || (taken && (bp_predict_address_i != tgt));
    end
    misaligned = taken && (RVC ? tgt[0] : (tgt[1:0] != 2'b00));
  end

  // Flags drop to 0 when idle; data fields keep their last resolved value.
  // ex_tval only tracks the most recent misaligned target.
  always_comb begin
    result_d     = result_q;
    valid_d      = 1'b0;
    pc_d         = pc_q;
    target_d     = target_q;
    taken_d      = taken_q;
    mispredict_d = 1'b0;
    cf_type_d    = cf_type_q;
    ex_valid_d   = 1'b0;
    ex_cause_d   = ex_cause_q;
    ex_tval_d    = ex_tval_q;
    if (act) begin
      result_d     = next_pc;
      valid_d      = 1'b1;
      pc_d         = pc_i;
      target_d     = taken ? tgt : next_pc;
      taken_d      = taken;
      mispredict_d = mispredict;
      cf_type_d    = is_jalr_i ? CF_JUMPR : CF_BRANCH;
      if (misaligned) begin
        ex_valid_d = !debug_mode_i;
        ex_cause_d = '0;
        ex_tval_d  = XLEN'($signed(tgt));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q     <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      target_q     <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      cf_type_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_cause_q   <= '0;
      ex_tval_q    <= '0;
    end else begin
      result_q     <= result_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      cf_type_q    <= cf_type_d;
      ex_valid_q   <= ex_valid_d;
      ex_cause_q   <= ex_cause_d;
      ex_tval_q    <= ex_tval_d;
    end
  end

  assign branch_result_o     = result_q;
  assign resolve_branch_o    = valid_q;
  assign res_valid_o         = valid_q;
  assign res_pc_o            = pc_q;
  assign res_target_o        = target_q;
  assign res_is_taken_o      = taken_q;
  assign res_is_mispredict_o = mispredict_q;
  assign res_cf_type_o       = cf_type_q;
  assign ex_valid_o          = ex_valid_q;
  assign ex_cause_o          = ex_cause_q;
  assign ex_tval_o           = ex_tval_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus a randomized
// back-to-back stream with mid-stream resets, checked against a reference model.
// Two instances share all inputs: one with 4-byte alignment, one with RVC.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dbg, fu_v, br_v, jalr, comp, cmp;
  logic [63:0] opa, imm, pc, pred;
  logic [2:0]  bpcf;

  logic [63:0] result, rpc, target, cause, tval;
  logic        resolve, valid, taken, misp, exv;
  logic [2:0]  cf;

  logic [63:0] c_result, c_rpc, c_target, c_cause, c_tval;
  logic        c_resolve, c_valid, c_taken, c_misp, c_exv;
  logic [2:0]  c_cf;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.VLEN(64), .XLEN(64), .RVC(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .debug_mode_i(dbg), .fu_valid_i(fu_v),
    .branch_valid_i(br_v), .is_jalr_i(jalr), .operand_a_i(opa), .imm_i(imm),
    .pc_i(pc), .is_compressed_instr_i(comp), .branch_comp_res_i(cmp),
    .bp_cf_i(bpcf), .bp_predict_address_i(pred),
    .branch_result_o(result), .resolve_branch_o(resolve), .res_valid_o(valid),
    .res_pc_o(rpc), .res_target_o(target), .res_is_taken_o(taken),
    .res_is_mispredict_o(misp), .res_cf_type_o(cf), .ex_valid_o(exv),
    .ex_cause_o(cause), .ex_tval_o(tval)
  );

  branch_resolve_unit #(.VLEN(64), .XLEN(64), .RVC(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .debug_mode_i(dbg), .fu_valid_i(fu_v),
    .branch_valid_i(br_v), .is_jalr_i(jalr), .operand_a_i(opa), .imm_i(imm),
    .pc_i(pc), .is_compressed_instr_i(comp), .branch_comp_res_i(cmp),
    .bp_cf_i(bpcf), .bp_predict_address_i(pred),
    .branch_result_o(c_result), .resolve_branch_o(c_resolve), .res_valid_o(c_valid),
    .res_pc_o(c_rpc), .res_target_o(c_target), .res_is_taken_o(c_taken),
    .res_is_mispredict_o(c_misp), .res_cf_type_o(c_cf), .ex_valid_o(c_exv),
    .ex_cause_o(c_cause), .ex_tval_o(c_tval)
  );

  typedef struct packed {
    logic        fu, bv, jalr, dbg, comp, cmp;
    logic [63:0] a, imm, pc, pred;
    logic [2:0]  bpcf;
  } in_t;

  typedef struct packed {
    logic [63:0] result, pc, target, tval0, tval1;
    logic        valid, taken, misp, ex0, ex1;
    logic [2:0]  cf;
  } exp_t;

  // Architectural behaviour of one issue slot; p is the previously visible record.
  function automatic exp_t model(in_t s, exp_t p);
    exp_t        e;
    logic [63:0] npc, t;
    logic        tk, mal4, mal2;
    e       = p;
    e.valid = 1'b0;
    e.misp  = 1'b0;
    e.ex0   = 1'b0;
    e.ex1   = 1'b0;
    if (!(s.fu && s.bv)) return e;
    npc = s.pc + (s.comp ? 64'd2 : 64'd4);
    if (s.jalr) begin
      t    = s.a + s.imm;
      t[0] = 1'b0;
      tk   = 1'b1;
      e.cf = 3'd3;
      e.misp = !(s.bpcf == 3'd3 || s.bpcf == 3'd4) || (s.pred != t);
    end else begin
      t    = s.pc + s.imm;
      tk   = s.cmp;
      e.cf = 3'd1;
      e.misp = (tk != (s.bpcf == 3'd1)) || (tk && s.pred != t);
    end
    e.result = npc;
    e.pc     = s.pc;
    e.target = tk ? t : npc;
    e.taken  = tk;
    e.valid  = 1'b1;
    mal4     = tk && (t % 4 != 0);
    mal2     = tk && (t % 2 != 0);
    e.ex0    = mal4 && !s.dbg;
    e.ex1    = mal2 && !s.dbg;
    if (mal4) e.tval0 = t;
    if (mal2) e.tval1 = t;
    return e;
  endfunction

  task automatic drive(in_t s);
    fu_v = s.fu; br_v = s.bv; jalr = s.jalr; dbg = s.dbg; comp = s.comp;
    cmp = s.cmp; opa = s.a; imm = s.imm; pc = s.pc; pred = s.pred; bpcf = s.bpcf;
  endtask

  function automatic in_t idle_in();
    in_t s;
    s = '0;
    return s;
  endfunction

  function automatic in_t op(logic j, logic [63:0] a, logic [63:0] im, logic [63:0] p,
                             logic c, logic cm, logic [2:0] bc, logic [63:0] pr, logic d);
    in_t s;
    s = '0;
    s.fu = 1'b1; s.bv = 1'b1; s.jalr = j; s.a = a; s.imm = im; s.pc = p;
    s.comp = c; s.cmp = cm; s.bpcf = bc; s.pred = pr; s.dbg = d;
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(op(1'b1, 64'h1003, 64'h0, 64'h40, 1'b0, 1'b1, 3'd0, 64'h0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({result, rpc, target, tval, cause, resolve, valid, taken, misp, exv, cf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got res=%h pc=%h tgt=%h tval=%h cause=%h flags=%b cf=%0d exp all 0",
               result, rpc, target, tval, cause, {resolve, valid, taken, misp, exv}, cf);
    end
    rst = 1'b0;
    drive(idle_in());
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({result, rpc, target, tval, cause, resolve, valid, taken, misp, exv, cf,
         c_result, c_target, c_valid, c_exv} !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle got res=%h tgt=%h valid=%b exv=%b cf=%0d exp all 0",
               result, target, valid, exv, cf);
    end
  endtask

  task automatic test_jalr_basic();
    drive(op(1'b1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 3'd1, 64'h4, 1'b0));
    @(posedge clk); #1;
    drive(idle_in());
    n_checks++;
    if ({result, target, taken, cf, misp, valid, resolve, exv, cause, tval} !==
        {64'h4, 64'h0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL jalr_basic got res=%h tgt=%h tk=%b cf=%0d misp=%b v=%b rs=%b exv=%b cause=%h tval=%h exp res=4 tgt=0 tk=1 cf=3 misp=1 v=1 rs=1 exv=0 cause=0 tval=0",
               result, target, taken, cf, misp, valid, resolve, exv, cause, tval);
    end
    // Idle cycle: flags drop, data holds.
    @(posedge clk); #1;
    n_checks++;
    if ({valid, resolve, misp, exv, result, cf} !== {4'b0000, 64'h4, 3'd3}) begin
      n_fail++;
      $display("FAIL idle_hold got v=%b rs=%b misp=%b exv=%b res=%h cf=%0d exp flags 0 res=4 cf=3",
               valid, resolve, misp, exv, result, cf);
    end
  endtask

  task automatic test_branch_taken();
    drive(op(1'b0, 64'h0, 64'h40, 64'h100, 1'b0, 1'b1, 3'd1, 64'h140, 1'b0));
    @(posedge clk); #1;
    drive(idle_in());
    n_checks++;
    if ({target, taken, misp, cf, result, rpc, valid} !==
        {64'h140, 1'b1, 1'b0, 3'd1, 64'h104, 64'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL branch_taken got tgt=%h tk=%b misp=%b cf=%0d res=%h pc=%h v=%b exp tgt=140 tk=1 misp=0 cf=1 res=104 pc=100 v=1",
               target, taken, misp, cf, result, rpc, valid);
    end
  endtask

  task automatic test_branch_not_taken();
    drive(op(1'b0, 64'h0, 64'h40, 64'h100, 1'b1, 1'b0, 3'd1, 64'h140, 1'b0));
    @(posedge clk); #1;
    drive(idle_in());
    n_checks++;
    if ({target, result, taken, misp, exv} !== {64'h102, 64'h102, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_not_taken got tgt=%h res=%h tk=%b misp=%b exv=%b exp tgt=102 res=102 tk=0 misp=1 exv=0",
               target, result, taken, misp, exv);
    end
  endtask

  task automatic test_misaligned();
    drive(op(1'b1, 64'h1002, 64'h0, 64'h200, 1'b0, 1'b0, 3'd3, 64'h1002, 1'b0));
    @(posedge clk); #1;
    n_checks++;
    if ({exv, cause, tval, valid, target, misp} !== {1'b1, 64'h0, 64'h1002, 1'b1, 64'h1002, 1'b0}) begin
      n_fail++;
      $display("FAIL misaligned_ex got exv=%b cause=%h tval=%h v=%b tgt=%h misp=%b exp exv=1 cause=0 tval=1002 v=1 tgt=1002 misp=0",
               exv, cause, tval, valid, target, misp);
    end
    n_checks++;
    if (c_exv !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_rvc_ok got exv=%b exp 0", c_exv);
    end
    // Same target in debug mode: record reported, exception suppressed.
    drive(op(1'b1, 64'h1002, 64'h0, 64'h200, 1'b0, 1'b0, 3'd3, 64'h1002, 1'b1));
    @(posedge clk); #1;
    n_checks++;
    if ({exv, valid, resolve} !== 3'b011) begin
      n_fail++;
      $display("FAIL misaligned_debug got exv=%b v=%b rs=%b exp exv=0 v=1 rs=1", exv, valid, resolve);
    end
    // Negative odd target: tval sign-extension and the RVC instance fault.
    drive(op(1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 1'b0, 1'b1, 3'd1, 64'h0, 1'b0));
    @(posedge clk); #1;
    drive(idle_in());
    n_checks++;
    if ({exv, tval, c_exv, c_tval} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1}) begin
      n_fail++;
      $display("FAIL misaligned_neg got exv=%b tval=%h c_exv=%b c_tval=%h exp 1 fff..f1 1 fff..f1",
               exv, tval, c_exv, c_tval);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        cur;
    in_t         s;
    logic        r;
    logic [63:0] good;
    cur = '0;
    rst = 1'b1;
    drive(idle_in());
    @(posedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 400; i++) begin
      s      = '0;
      s.fu   = ($urandom_range(0, 7) != 0);
      s.bv   = ($urandom_range(0, 7) != 0);
      s.jalr = $urandom_range(0, 1);
      s.dbg  = ($urandom_range(0, 5) == 0);
      s.comp = $urandom_range(0, 1);
      s.cmp  = $urandom_range(0, 1);
      s.a    = {$urandom, $urandom};
      s.imm  = ($urandom_range(0, 1) != 0) ? 64'($signed(12'($urandom))) : {$urandom, $urandom};
      s.pc   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) s.pc = 64'hFFFF_FFFF_FFFF_FFFE;
      s.bpcf = 3'($urandom_range(0, 4));
      good   = s.jalr ? ((s.a + s.imm) & ~64'd1) : (s.pc + s.imm);
      s.pred = ($urandom_range(0, 1) != 0) ? good : {$urandom, $urandom};
      r      = ($urandom_range(0, 24) == 0);
      rst    = r;
      drive(s);
      @(posedge clk); #1;
      cur = r ? exp_t'('0) : model(s, cur);
      n_checks++;
      if ({valid, resolve} !== {2{cur.valid}}) begin
        n_fail++;
        $display("FAIL b2b_valid cyc=%0d got v=%b rs=%b exp %b", i, valid, resolve, cur.valid);
      end
      n_checks++;
      if ({result, rpc, target} !== {cur.result, cur.pc, cur.target}) begin
        n_fail++;
        $display("FAIL b2b_data cyc=%0d got res=%h pc=%h tgt=%h exp res=%h pc=%h tgt=%h",
                 i, result, rpc, target, cur.result, cur.pc, cur.target);
      end
      n_checks++;
      if ({taken, misp, cf} !== {cur.taken, cur.misp, cur.cf}) begin
        n_fail++;
        $display("FAIL b2b_decision cyc=%0d got tk=%b misp=%b cf=%0d exp tk=%b misp=%b cf=%0d",
                 i, taken, misp, cf, cur.taken, cur.misp, cur.cf);
      end
      n_checks++;
      if ({exv, c_exv, cause, c_cause} !== {cur.ex0, cur.ex1, 128'h0}) begin
        n_fail++;
        $display("FAIL b2b_exc cyc=%0d got exv=%b c_exv=%b cause=%h exp exv=%b c_exv=%b cause=0",
                 i, exv, c_exv, cause, cur.ex0, cur.ex1);
      end
      if (cur.ex0) begin
        n_checks++;
        if (tval !== cur.tval0) begin
          n_fail++;
          $display("FAIL b2b_tval cyc=%0d got %h exp %h", i, tval, cur.tval0);
        end
      end
      if (cur.ex1) begin
        n_checks++;
        if (c_tval !== cur.tval1) begin
          n_fail++;
          $display("FAIL b2b_tval_rvc cyc=%0d got %h exp %h", i, c_tval, cur.tval1);
        end
      end
      n_checks++;
      if ({c_result, c_target, c_valid, c_misp} !== {cur.result, cur.target, cur.valid, cur.misp}) begin
        n_fail++;
        $display("FAIL b2b_rvc_inst cyc=%0d got res=%h tgt=%h v=%b misp=%b exp res=%h tgt=%h v=%b misp=%b",
                 i, c_result, c_target, c_valid, c_misp, cur.result, cur.target, cur.valid, cur.misp);
      end
    end
    rst = 1'b0;
    drive(idle_in());
  endtask

  initial begin
    rst = 1'b1;
    drive(idle_in());
    @(negedge clk);
    test_reset();
    test_jalr_basic();
    test_branch_taken();
    test_branch_not_taken();
    test_misaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
